cnt_gate_ctrl: RTL
==================

Name: cnt_gate_ctrl

Overview:
- Measurement-window sequencer for the pulse-counter array.
- Configured from the SPI command path with a channel enable mask and a gate period in timebase ticks.
- Runs gated windows; at each window end it captures all counter outputs into a snapshot and clears the counters.
- Serves SPI readout from a double-buffered register, so reads never tear and never stall counting.

Parameters:
- NUMBER_OF_COUNTERS, 16, number of counter channels.
- COUNTERS_WIDTH, 8, width of each counter.
- GATE_WIDTH, 16, width of the gate period field, in ticks.
- CLR_CYCLES, 32, number of i_clk cycles o_cnt_rst is held. Must be at least one divided-clock period of the counters.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset: asynchronous, active-high.
- i_tick  in  1  one-cycle timebase strobe.
- i_cfg_valid  in  1  one-cycle strobe: new configuration present.
- i_cfg_enable  in  NUMBER_OF_COUNTERS  channel enable mask.
- i_cfg_period  in  GATE_WIDTH  window length in ticks; 0 = gating off.
- o_cnt_en  out  NUMBER_OF_COUNTERS  per-counter enable.
- o_cnt_rst  out  1  synchronous clear to all counters.
- i_cnt_data  in  NUMBER_OF_COUNTERS*COUNTERS_WIDTH  packed counter outputs, channel i at [W*i +: W].
- i_rd_req  in  1  SPI TX data request strobe.
- i_rd_busy  in  1  SPI shifting, i.e. data taken.
- o_rd_valid  out  1  o_rd_data valid for SPI load.
- o_rd_data  out  NUMBER_OF_COUNTERS*COUNTERS_WIDTH  readout buffer.
- o_gate_active  out  1  high while in RUN.
- o_overrun  out  1  sticky: an unread snapshot was overwritten.

Behaviour:
- Reset values:
  - state IDLE; enable and period registers 0.
  - o_cnt_en 0, o_cnt_rst 0, o_rd_valid 0, o_rd_data 0, o_gate_active 0, o_overrun 0.
  - snapshot 0, snap_full 0, rd_pending 0.
- States:
  - IDLE: o_cnt_en=0.
  - CLEAR: o_cnt_rst=1 and o_cnt_en=0 for exactly CLR_CYCLES cycles. On exit go to RUN if period!=0 and mask!=0, else IDLE.
  - RUN: o_cnt_en=mask. Tick counter increments on each i_tick. On the i_tick where count==period-1, go to CAPTURE.
  - CAPTURE: one cycle. o_cnt_en=0; snapshot<=i_cnt_data. If snap_full was already 1, set o_overrun. Set snap_full=1, then go to CLEAR.
- Window length = period ticks. The tick counter resets on entry to RUN.
- Configuration:
  - i_cfg_valid is accepted in any state. It latches mask and period, clears o_overrun, aborts the current window without capturing, and forces CLEAR (restarting the CLR_CYCLES count if already in CLEAR).
  - If i_cfg_valid and the capture condition occur in the same cycle, i_cfg_valid wins and no capture takes place.
- Readout, independent of the state machine:
  - i_rd_req sets rd_pending.
  - When rd_pending && snap_full && !o_rd_valid: o_rd_data<=snapshot and o_rd_valid<=1 on the next cycle; clear rd_pending and snap_full.
  - o_rd_valid holds until i_rd_busy is seen high, then drops on the next cycle.
  - o_rd_data is stable while o_rd_valid=1 and is never modified by CAPTURE.
  - A request made with no snapshot stays pending until the next CAPTURE. Latency: o_rd_valid is asserted 1 cycle after snap_full is set.
  - If CAPTURE and a grant happen in the same cycle, the grant uses the old snapshot and snap_full stays 1 with the new data.
  - i_rd_req while o_rd_valid=1 is remembered as rd_pending.
- Reset mid-operation returns everything to reset values immediately. Counters are not cleared by this block on reset; they share i_rst.

Decomposition:
- Shared package holds:
  - state encodings IDLE/CLEAR/RUN/CAPTURE, 2 bits;
  - CLR_CYCLES default;
  - the counter packing helper constant W*i.
- Sub-module gate_timer: GATE_WIDTH tick counter with clear, enable, i_tick, period input and o_expire output (= i_tick && count==period-1).

Test Plan:
- Reset, then cfg mask=16'h0005, period=4, i_tick=1 every cycle → o_cnt_rst high for 32 cycles, then o_gate_active high for 4 cycles, CAPTURE, CLEAR repeats; o_cnt_en=16'h0005 only in RUN.
- Drive i_cnt_data ch0=8'h12, ch2=8'h34 at capture, then pulse i_rd_req → o_rd_valid after 1 cycle, o_rd_data[7:0]=8'h12, [23:16]=8'h34; raise i_rd_busy → o_rd_valid drops next cycle.
- Two captures with no read → o_overrun=1 and the snapshot holds the second window's values; a new i_cfg_valid → o_overrun=0.
- i_rd_req before the first capture → o_rd_valid stays 0 until 1 cycle after the first CAPTURE.
- i_cfg_valid on the capture cycle with period=0 → no capture, 32-cycle clear, then IDLE with o_cnt_en=0.
- Assert i_rst during RUN with o_rd_valid=1 → all outputs 0 asynchronously; after release the block stays in IDLE until i_cfg_valid.

Source files
------------

// File: rtl/cnt_gate_ctrl_pkg.sv
// cnt_gate_ctrl_pkg: shared FSM encoding, clear-length default and counter lane packing helper
package cnt_gate_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    RUN     = 2'd2,
    CAPTURE = 2'd3
  } state_e;
  localparam int CLR_CYCLES_DEF = 32;
  function automatic int lane_lsb(input int w, input int i);
    return w * i;
  endfunction
endpackage

// File: rtl/cnt_gate_ctrl_gate_timer.sv
// gate_timer: window tick counter; i_clk/i_rst, i_clr zeroes, i_en+i_tick count, o_expire on the tick where count==i_period-1
module gate_timer #(
  parameter int GATE_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  input  logic                  i_en,
  input  logic                  i_tick,
  input  logic [GATE_WIDTH-1:0] i_period,
  output logic                  o_expire
);
  logic [GATE_WIDTH-1:0] count_q, count_d;
  always_comb begin
    o_expire = i_en && i_tick && (count_q == i_period - GATE_WIDTH'(1));
    count_d  = i_clr ? '0 : (i_en && i_tick) ? (o_expire ? '0 : count_q + GATE_WIDTH'(1)) : count_q;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) count_q <= '0;
    else       count_q <= count_d;
  end
endmodule

// File: rtl/cnt_gate_ctrl.sv
// cnt_gate_ctrl: gated-window sequencer (cfg in, counter en/clear out) with double-buffered snapshot readout (rd req/busy/valid/data, overrun)
module cnt_gate_ctrl
  import cnt_gate_ctrl_pkg::*;
#(
  parameter int NUMBER_OF_COUNTERS = 16,
  parameter int COUNTERS_WIDTH     = 8,
  parameter int GATE_WIDTH         = 16,
  parameter int CLR_CYCLES         = CLR_CYCLES_DEF
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_tick,
  input  logic                                   i_cfg_valid,
  input  logic [NUMBER_OF_COUNTERS-1:0]          i_cfg_enable,
  input  logic [GATE_WIDTH-1:0]                  i_cfg_period,
  output logic [NUMBER_OF_COUNTERS-1:0]          o_cnt_en,
  output logic                                   o_cnt_rst,
  input  logic [NUMBER_OF_COUNTERS*COUNTERS_WIDTH-1:0] i_cnt_data,
  input  logic                                   i_rd_req,
  input  logic                                   i_rd_busy,
  output logic                                   o_rd_valid,
  output logic [NUMBER_OF_COUNTERS*COUNTERS_WIDTH-1:0] o_rd_data,
  output logic                                   o_gate_active,
  output logic                                   o_overrun
);
  localparam int DW = NUMBER_OF_COUNTERS * COUNTERS_WIDTH;
  localparam int CW = $clog2(CLR_CYCLES + 1);
  state_e                        state_q, state_d;
  logic [CW-1:0]                 clr_q, clr_d;
  logic [NUMBER_OF_COUNTERS-1:0] mask_q, mask_d;
  logic [GATE_WIDTH-1:0]         period_q, period_d;
  logic [DW-1:0]                 snap_q, snap_d, rd_data_q, rd_data_d;
  logic                          snap_full_q, snap_full_d;
  logic                          rd_pending_q, rd_pending_d;
  logic                          rd_valid_q, rd_valid_d;
  logic                          overrun_q, overrun_d;
  logic                          expire, capture, grant, clr_done;
  gate_timer #(.GATE_WIDTH(GATE_WIDTH)) u_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (state_q != RUN),
    .i_en     (state_q == RUN),
    .i_tick   (i_tick),
    .i_period (period_q),
    .o_expire (expire)
  );
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      clr_q    <= '0;
      mask_q   <= '0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      clr_q    <= clr_d;
      mask_q   <= mask_d;
      period_q <= period_d;
    end
  end
  always_comb begin
    clr_done = clr_q == CW'(CLR_CYCLES - 1);
    mask_d   = i_cfg_valid ? i_cfg_enable : mask_q;
    period_d = i_cfg_valid ? i_cfg_period : period_q;
    clr_d    = (i_cfg_valid || state_q != CLEAR) ? '0 : clr_q + CW'(1);
    state_d  = i_cfg_valid         ? CLEAR :
               state_q == CLEAR    ? (clr_done ? ((period_q != '0 && mask_q != '0) ? RUN : IDLE) : CLEAR) :
               state_q == RUN      ? (expire ? CAPTURE : RUN) :
               state_q == CAPTURE  ? CLEAR : IDLE;
  end
  always_comb begin
    o_cnt_en      = state_q == RUN ? mask_q : '0;
    o_cnt_rst     = state_q == CLEAR;
    o_gate_active = state_q == RUN;
    capture       = state_q == CAPTURE && !i_cfg_valid;
  end
  always_comb begin
    grant        = rd_pending_q && snap_full_q && !rd_valid_q;
    snap_d       = capture ? i_cnt_data : snap_q;
    snap_full_d  = capture ? 1'b1 : grant ? 1'b0 : snap_full_q;
    rd_pending_d = i_rd_req || (rd_pending_q && !grant);
    rd_valid_d   = grant ? 1'b1 : (rd_valid_q && i_rd_busy) ? 1'b0 : rd_valid_q;
    rd_data_d    = grant ? snap_q : rd_data_q;
    overrun_d    = i_cfg_valid ? 1'b0 : (capture && snap_full_q && !grant) ? 1'b1 : overrun_q;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      snap_q       <= '0;
      snap_full_q  <= 1'b0;
      rd_pending_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      overrun_q    <= 1'b0;
    end else begin
      snap_q       <= snap_d;
      snap_full_q  <= snap_full_d;
      rd_pending_q <= rd_pending_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      overrun_q    <= overrun_d;
    end
  end
  assign o_rd_valid = rd_valid_q;
  assign o_rd_data  = rd_data_q;
  assign o_overrun  = overrun_q;
endmodule
